// File: rtl/serial_rx_align.sv
// Serial lane receiver front end: comma-based byte alignment, lock qualification
// over consecutive aligned commas, and FIFO write strobes gated by almost_full.
module serial_rx_align #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4,
    parameter int         CNT_W      = 8
) (
    input  logic             i_clk8f,
    input  logic             i_reset,
    input  logic             i_data_in,
    input  logic             i_almost_full,
    output logic [7:0]       o_data_out,
    output logic             o_write_out,
    output logic             o_active,
    output logic [CNT_W-1:0] o_drop_cnt
);

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        ACTIVE
    } state_t;

    // Comparing against LOCK_COUNT-1 lets the comma being checked count toward lock.
    localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_sr;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       w_bit_cnt_next;
    logic [3:0]       r_bc_cnt;
    logic [3:0]       w_bc_cnt_next;
    logic [7:0]       r_data_out;
    logic [7:0]       w_data_out_next;
    logic             r_write_out;
    logic             w_write_out_next;
    logic             r_active;
    logic             w_active_next;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] w_drop_cnt_next;
    logic             w_is_comma;
    logic             w_boundary;

    assign w_is_comma = (r_sr == COMMA);
    assign w_boundary = (r_state != SEARCH) && (r_bit_cnt == 3'd7);

    always_comb begin
        w_state_next     = r_state;
        w_bit_cnt_next   = r_bit_cnt;
        w_bc_cnt_next    = r_bc_cnt;
        w_data_out_next  = r_data_out;
        w_write_out_next = 1'b0;
        w_active_next    = r_active;
        w_drop_cnt_next  = r_drop_cnt;

        case (r_state)
            SEARCH: begin
                if (w_is_comma) begin
                    w_state_next   = ALIGN;
                    w_bit_cnt_next = 3'd0;
                    w_bc_cnt_next  = 4'd1;
                end
            end
            ALIGN: begin
                w_bit_cnt_next = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    if (w_is_comma) begin
                        w_bc_cnt_next = r_bc_cnt + 4'd1;
                        if (r_bc_cnt == LOCK_LAST) begin
                            w_state_next  = ACTIVE;
                            w_active_next = 1'b1;
                        end
                    end else begin
                        w_state_next  = SEARCH;
                        w_bc_cnt_next = 4'd0;
                    end
                end
            end
            ACTIVE: begin
                w_bit_cnt_next = r_bit_cnt + 3'd1;
                // Commas are idle fill; only data bytes reach the FIFO or the drop counter.
                if (w_boundary && !w_is_comma) begin
                    if (!i_almost_full) begin
                        w_data_out_next  = r_sr;
                        w_write_out_next = 1'b1;
                    end else if (!(&r_drop_cnt)) begin
                        w_drop_cnt_next = r_drop_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = SEARCH;
            end
        endcase
    end

    always_ff @(posedge i_clk8f) begin
        if (i_reset) begin
            r_state     <= SEARCH;
            r_sr        <= 8'd0;
            r_bit_cnt   <= 3'd0;
            r_bc_cnt    <= 4'd0;
            r_data_out  <= 8'd0;
            r_write_out <= 1'b0;
            r_active    <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_sr        <= {r_sr[6:0], i_data_in};
            r_bit_cnt   <= w_bit_cnt_next;
            r_bc_cnt    <= w_bc_cnt_next;
            r_data_out  <= w_data_out_next;
            r_write_out <= w_write_out_next;
            r_active    <= w_active_next;
            r_drop_cnt  <= w_drop_cnt_next;
        end
    end

    assign o_data_out  = r_data_out;
    assign o_write_out = r_write_out;
    assign o_active    = r_active;
    assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_serial_rx_align.sv
// Self-checking bench for serial_rx_align: byte vectors from a table plus
// hand-written lock/reset/saturation sequences, with a write scoreboard.
module tb_serial_rx_align;

    logic       clk;
    logic       reset;
    logic       data_in;
    logic       almost_full;
    logic [7:0] data_out;
    logic       write_out;
    logic       active;
    logic [7:0] drop_cnt;

    serial_rx_align dut (
        .i_clk8f      (clk),
        .i_reset      (reset),
        .i_data_in    (data_in),
        .i_almost_full(almost_full),
        .o_data_out   (data_out),
        .o_write_out  (write_out),
        .o_active     (active),
        .o_drop_cnt   (drop_cnt)
    );

    typedef struct {
        logic [7:0] byteIn;
        logic       af;
        logic       expWrite;
        logic       expActive;
        logic [7:0] expData;
        logic [7:0] expDrop;
    } vec_t;

    vec_t       vecs[24];
    int         lastEdgeArr[24];
    logic [7:0] expQ[$];
    int         writeStamps[$];
    int         total = 0;
    int         bad = 0;
    int         cycleCnt = 0;
    int         activeRiseCycle = -1;
    logic       prevWrite = 1'b0;
    logic       prevActive = 1'b0;
    logic       afPrev = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard side: every write strobe must match the oldest expected byte.
    always @(negedge clk) begin
        if (write_out) begin
            writeStamps.push_back(cycleCnt);
            checkOutput("writeSingleCycle", {31'd0, prevWrite}, 32'd0);
            checkOutput("writeHasExpected", {31'd0, (expQ.size() != 0)}, 32'd1);
            if (expQ.size() != 0) checkOutput("writeData", {24'd0, data_out}, {24'd0, expQ.pop_front()});
        end
        if (active && !prevActive) activeRiseCycle = cycleCnt;
        prevWrite  = write_out;
        prevActive = active;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyReset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset       = 1'b1;
            data_in     = i[0];
            almost_full = 1'b0;
        end
        @(negedge clk);
        reset   = 1'b0;
        data_in = 1'b0;
        afPrev  = 1'b0;
        writeStamps.delete();
        activeRiseCycle = -1;
    endtask

    // The almost_full value for a byte is driven in its boundary cycle, i.e. with the next bit.
    task automatic sendBit(input logic b);
        @(negedge clk);
        data_in     = b;
        almost_full = afPrev;
        afPrev      = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic af, output int lastEdge);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            data_in     = b[i];
            almost_full = (i == 7) ? afPrev : 1'b0;
        end
        lastEdge = cycleCnt + 1;
        afPrev   = af;
    endtask

    task automatic runVectors(input int lo, input int hi);
        int e;
        for (int i = lo; i <= hi; i++) begin
            applyStimulus(vecs[i].byteIn, vecs[i].af, e);
            lastEdgeArr[i] = e;
            if (vecs[i].expWrite) expQ.push_back(vecs[i].byteIn);
            checkOutput($sformatf("vec%0d active", i), {31'd0, active}, {31'd0, vecs[i].expActive});
            checkOutput($sformatf("vec%0d data_out", i), {24'd0, data_out}, {24'd0, vecs[i].expData});
            checkOutput($sformatf("vec%0d drop_cnt", i), {24'd0, drop_cnt}, {24'd0, vecs[i].expDrop});
        end
    endtask

    initial begin
        int e;
        int e4;
        int e12;
        logic [7:0] b11;

        // byteIn, af, expWrite, then active/data_out/drop_cnt seen while this byte shifts in
        vecs[0]  = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0};
        vecs[1]  = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0};
        vecs[2]  = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0};
        vecs[3]  = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0};
        vecs[4]  = '{8'hBC, 1'b0, 1'b0, 1'b1, 8'h00, 8'd0};
        vecs[5]  = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'h00, 8'd0};
        vecs[6]  = '{8'hDD, 1'b0, 1'b1, 1'b1, 8'hFF, 8'd0};
        vecs[7]  = '{8'hEE, 1'b0, 1'b1, 1'b1, 8'hDD, 8'd0};
        vecs[8]  = '{8'hCC, 1'b0, 1'b1, 1'b1, 8'hEE, 8'd0};
        vecs[9]  = '{8'h99, 1'b0, 1'b1, 1'b1, 8'hCC, 8'd0};
        vecs[10] = '{8'hAA, 1'b0, 1'b1, 1'b1, 8'h99, 8'd0};
        vecs[11] = '{8'h88, 1'b0, 1'b1, 1'b1, 8'hAA, 8'd0};
        vecs[12] = '{8'hBC, 1'b0, 1'b0, 1'b1, 8'h88, 8'd0};
        vecs[13] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0};
        vecs[14] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0};
        vecs[15] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0};
        vecs[16] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0};
        vecs[17] = '{8'hBC, 1'b1, 1'b0, 1'b1, 8'h00, 8'd0};
        vecs[18] = '{8'h5A, 1'b0, 1'b1, 1'b1, 8'h00, 8'd0};
        vecs[19] = '{8'hA1, 1'b1, 1'b0, 1'b1, 8'h5A, 8'd0};
        vecs[20] = '{8'hA2, 1'b1, 1'b0, 1'b1, 8'h5A, 8'd1};
        vecs[21] = '{8'hA3, 1'b0, 1'b1, 1'b1, 8'h5A, 8'd2};
        vecs[22] = '{8'hBC, 1'b0, 1'b0, 1'b1, 8'hA3, 8'd2};
        vecs[23] = '{8'hBC, 1'b0, 1'b0, 1'b1, 8'hA3, 8'd2};

        reset       = 1'b1;
        data_in     = 1'b0;
        almost_full = 1'b0;

        // T1: long reset with toggling data, then idle zeros
        $display("[TB] T1 reset");
        applyReset(6);
        checkOutput("t1 data_out", {24'd0, data_out}, 32'd0);
        checkOutput("t1 write_out", {31'd0, write_out}, 32'd0);
        checkOutput("t1 active", {31'd0, active}, 32'd0);
        checkOutput("t1 drop_cnt", {24'd0, drop_cnt}, 32'd0);
        for (int i = 0; i < 20; i++) sendBit(1'b0);
        checkOutput("t1 idle active", {31'd0, active}, 32'd0);
        checkOutput("t1 no rise", activeRiseCycle, 32'hFFFF_FFFF);

        // T2: preamble, lock on 4th comma, seven data writes 8 cycles apart
        $display("[TB] T2 lock and stream");
        applyReset(2);
        sendBit(1'b0); sendBit(1'b1); sendBit(1'b0);
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
        runVectors(0, 12);
        checkOutput("t2 active rise", activeRiseCycle, lastEdgeArr[3] + 1);
        checkOutput("t2 write count", writeStamps.size(), 32'd7);
        if (writeStamps.size() == 7) begin
            checkOutput("t2 first latency", writeStamps[0], lastEdgeArr[5] + 1);
            for (int i = 1; i < 7; i++)
                checkOutput($sformatf("t2 gap%0d", i), writeStamps[i] - writeStamps[i-1], 32'd8);
        end
        checkOutput("t2 queue empty", expQ.size(), 32'd0);

        // T3: broken comma run sends the lane back to SEARCH
        $display("[TB] T3 relock");
        applyReset(2);
        for (int i = 0; i < 3; i++) applyStimulus(8'hBC, 1'b0, e);
        applyStimulus(8'h55, 1'b0, e);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'hBC, 1'b0, e);
            checkOutput($sformatf("t3 inactive bc%0d", i), {31'd0, active}, 32'd0);
        end
        e4 = e;
        applyStimulus(8'h3C, 1'b0, e);
        expQ.push_back(8'h3C);
        checkOutput("t3 active rise", activeRiseCycle, e4 + 1);
        applyStimulus(8'hBC, 1'b0, e);
        checkOutput("t3 data_out", {24'd0, data_out}, 32'h3C);
        checkOutput("t3 write count", writeStamps.size(), 32'd1);
        checkOutput("t3 queue empty", expQ.size(), 32'd0);

        // T4: almost_full drops two bytes, comma boundary with almost_full is not a drop
        $display("[TB] T4 almost_full");
        applyReset(2);
        runVectors(13, 23);
        checkOutput("t4 queue empty", expQ.size(), 32'd0);

        // T5: lock at an arbitrary bit offset
        $display("[TB] T5 offset lock");
        applyReset(2);
        b11 = 8'($urandom_range(0, 31));
        for (int i = 4; i >= 0; i--) sendBit(b11[i]);
        for (int i = 0; i < 4; i++) applyStimulus(8'hBC, 1'b0, e);
        applyStimulus(8'h12, 1'b0, e12);
        expQ.push_back(8'h12);
        applyStimulus(8'hBC, 1'b0, e);
        checkOutput("t5 active", {31'd0, active}, 32'd1);
        checkOutput("t5 write count", writeStamps.size(), 32'd1);
        if (writeStamps.size() == 1) checkOutput("t5 latency", writeStamps[0], e12 + 1);
        checkOutput("t5 queue empty", expQ.size(), 32'd0);

        // T6: reset mid-byte while active, then a fresh lock is required
        $display("[TB] T6 reset in active");
        applyReset(2);
        for (int i = 0; i < 4; i++) applyStimulus(8'hBC, 1'b0, e);
        applyStimulus(8'h77, 1'b1, e);
        applyStimulus(8'h66, 1'b0, e);
        expQ.push_back(8'h66);
        sendBit(1'b0); sendBit(1'b0); sendBit(1'b0);
        checkOutput("t6 pre drop", {24'd0, drop_cnt}, 32'd1);
        checkOutput("t6 pre data", {24'd0, data_out}, 32'h66);
        applyReset(1);
        checkOutput("t6 active", {31'd0, active}, 32'd0);
        checkOutput("t6 drop_cnt", {24'd0, drop_cnt}, 32'd0);
        checkOutput("t6 write_out", {31'd0, write_out}, 32'd0);
        checkOutput("t6 data_out", {24'd0, data_out}, 32'd0);
        applyStimulus(8'h42, 1'b0, e);
        applyStimulus(8'h43, 1'b0, e);
        checkOutput("t6 ignored active", {31'd0, active}, 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(8'hBC, 1'b0, e);
        applyStimulus(8'h44, 1'b0, e);
        expQ.push_back(8'h44);
        checkOutput("t6 relocked", {31'd0, active}, 32'd1);
        applyStimulus(8'hBC, 1'b0, e);
        checkOutput("t6 new data", {24'd0, data_out}, 32'h44);
        checkOutput("t6 queue empty", expQ.size(), 32'd0);

        // T7: drop counter saturates instead of wrapping
        $display("[TB] T7 drop saturation");
        applyReset(2);
        for (int i = 0; i < 4; i++) applyStimulus(8'hBC, 1'b0, e);
        for (int i = 0; i < 257; i++) applyStimulus(8'h33, 1'b1, e);
        applyStimulus(8'h34, 1'b0, e);
        expQ.push_back(8'h34);
        checkOutput("t7 drop sat", {24'd0, drop_cnt}, 32'hFF);
        applyStimulus(8'hBC, 1'b0, e);
        checkOutput("t7 drop hold", {24'd0, drop_cnt}, 32'hFF);
        checkOutput("t7 data_out", {24'd0, data_out}, 32'h34);
        checkOutput("t7 queue empty", expQ.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
